// File: rtl/srcv_ctrl_pkg.sv
// Shared definitions for the sample-rate-converter controller: instruction word
// geometry, field offsets and the program-sequencer state encoding.
package srcv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_PROG  = 2'd3
  } seq_state_e;

  // Word layout, MSB to LSB: lstg_f, startups_f, result_reg, error_reg,
  // data_bptr, data_lptr, data_hptr, filt_coef_ptr.
  function automatic int calc_iw(input int rw, input int dw);
    return 2 + 2 * rw + 4 * dw;
  endfunction

  function automatic int off_filt_coef(input int dw);
    return 0 * dw;
  endfunction

  function automatic int off_data_hptr(input int dw);
    return dw;
  endfunction

  function automatic int off_data_lptr(input int dw);
    return 2 * dw;
  endfunction

  function automatic int off_data_bptr(input int dw);
    return 3 * dw;
  endfunction

  function automatic int off_error_reg(input int dw);
    return 4 * dw;
  endfunction

  function automatic int off_result_reg(input int rw, input int dw);
    return 4 * dw + rw;
  endfunction

  function automatic int off_startups(input int rw, input int dw);
    return 4 * dw + 2 * rw;
  endfunction

  function automatic int off_lstg(input int rw, input int dw);
    return 4 * dw + 2 * rw + 1;
  endfunction

endpackage

// File: rtl/ctrl_prog_ram.sv
// Instruction store: one write port, one registered read port, no reset so it
// maps onto block RAM.
module ctrl_prog_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 22,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ctrl_prog_seq.sv
// Program sequencer: answers controller pointer requests with the next stored
// instruction word, wrapping at the last-stage flag.
module ctrl_prog_seq
  import srcv_ctrl_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 2,
  parameter int DATA_ADDR_WIDTH    = 4,
  parameter int PROG_SIZE          = 32,
  localparam int IW   = calc_iw(REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH),
  localparam int PC_W = $clog2(PROG_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            prog,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [IW-1:0]   prog_wdata,
  input  logic            ptr_req,
  output logic [IW-1:0]   instr_word,
  output logic            iw_valid,
  output logic [PC_W-1:0] pc,
  output logic            frame_done,
  output logic            seq_err
);

  localparam int LSTG_BIT = off_lstg(REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_SIZE - 1);

  seq_state_e      state_q, state_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            iw_valid_q, iw_valid_d;
  logic            frame_q, frame_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc_q, npc_d;
  logic            seq_err_q, seq_err_d;
  logic            rd_en;
  logic [IW-1:0]   rdata;

  // Writes depend only on prog so loading continues even while en is low.
  ctrl_prog_ram #(
    .DEPTH(PROG_SIZE),
    .WIDTH(IW)
  ) u_ram (
    .clk    (clk),
    .we_i   (prog & prog_we),
    .waddr_i(prog_addr),
    .wdata_i(prog_wdata),
    .re_i   (rd_en),
    .raddr_i(npc_q),
    .rdata_o(rdata)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    iw_valid_d = iw_valid_q;
    frame_d    = frame_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    seq_err_d  = seq_err_q;
    rd_en      = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (prog) begin
            state_d = ST_PROG;
          end else if (ptr_req) begin
            rd_en   = 1'b1;
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (prog) begin
            state_d = ST_PROG;
          end else begin
            instr_d    = rdata;
            pc_d       = npc_q;
            iw_valid_d = 1'b1;
            frame_d    = rdata[LSTG_BIT];
            state_d    = ST_ISSUE;
            if (rdata[LSTG_BIT]) begin
              npc_d = '0;
            end else if (npc_q == LAST_PC) begin
              npc_d     = '0;
              seq_err_d = 1'b1;
            end else begin
              npc_d = npc_q + PC_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          iw_valid_d = 1'b0;
          frame_d    = 1'b0;
          state_d    = prog ? ST_PROG : ST_IDLE;
        end
        ST_PROG: begin
          if (!prog) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      // Entering or staying in program mode discards any in-flight word.
      if (state_d == ST_PROG) begin
        iw_valid_d = 1'b0;
        frame_d    = 1'b0;
        pc_d       = '0;
        npc_d      = '0;
        seq_err_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      iw_valid_q <= 1'b0;
      frame_q    <= 1'b0;
      pc_q       <= '0;
      npc_q      <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      iw_valid_q <= iw_valid_d;
      frame_q    <= frame_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign instr_word = instr_q;
  assign iw_valid   = iw_valid_q;
  assign pc         = pc_q;
  assign frame_done = frame_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_ctrl_prog_seq.sv
// Directed bench for ctrl_prog_seq: a transaction-level model predicts every
// output each cycle; literal expectations pin the model on key transactions.
module tb_ctrl_prog_seq;

  localparam int IW   = 22;
  localparam int PC_W = 5;
  localparam int PS   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            prog = 1'b0;
  logic            prog_we = 1'b0;
  logic [PC_W-1:0] prog_addr = '0;
  logic [IW-1:0]   prog_wdata = '0;
  logic            ptr_req = 1'b0;
  logic [IW-1:0]   instr_word;
  logic            iw_valid;
  logic [PC_W-1:0] pc;
  logic            frame_done;
  logic            seq_err;

  ctrl_prog_seq dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .prog      (prog),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_wdata(prog_wdata),
    .ptr_req   (ptr_req),
    .instr_word(instr_word),
    .iw_valid  (iw_valid),
    .pc        (pc),
    .frame_done(frame_done),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a copy of the program plus the architectural expectations.
  logic [IW-1:0]   mdl_mem [PS];
  int              mdl_npc = 0;
  logic            exp_valid = 1'b0;
  logic            exp_fd = 1'b0;
  logic            exp_err = 1'b0;
  logic [IW-1:0]   exp_word = '0;
  logic [PC_W-1:0] exp_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("iw_valid", 32'(iw_valid), 32'(exp_valid));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("seq_err", 32'(seq_err), 32'(exp_err));
    chk("pc", 32'(pc), 32'(exp_pc));
    chk("instr_word", 32'(instr_word), 32'(exp_word));
  end

  function automatic logic [IW-1:0] mk(input logic lstg, input logic su, input logic [1:0] res,
                                       input logic [1:0] err, input logic [3:0] b,
                                       input logic [3:0] l, input logic [3:0] f);
    return {lstg, su, res, err, b, l, 4'b1000, f};
  endfunction

  // Issue the next word of the program and advance the walk pointer.
  task automatic model_issue();
    logic [IW-1:0] w;
    w         = mdl_mem[mdl_npc];
    exp_word  = w;
    exp_pc    = PC_W'(mdl_npc);
    exp_valid = 1'b1;
    exp_fd    = w[IW-1];
    if (w[IW-1]) mdl_npc = 0;
    else if (mdl_npc == PS - 1) begin
      mdl_npc = 0;
      exp_err = 1'b1;
    end else mdl_npc = mdl_npc + 1;
  endtask

  task automatic model_prog_clear();
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    exp_err   = 1'b0;
    exp_pc    = '0;
    mdl_npc   = 0;
  endtask

  task automatic enter_prog();
    @(posedge clk); #1 prog = 1'b1;
    @(posedge clk); #1 model_prog_clear();
  endtask

  task automatic wr(input int a, input logic [IW-1:0] d);
    prog_we = 1'b1; prog_addr = PC_W'(a); prog_wdata = d;
    @(posedge clk); #1 prog_we = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic exit_prog();
    prog = 1'b0;
    @(posedge clk); #1;
  endtask

  // One request; optional en=0 freeze in READ and in ISSUE.
  task automatic do_req(input int frz_rd, input int frz_is, input bit req_in_frz,
                        output logic [PC_W-1:0] opc, output logic [IW-1:0] ow,
                        output logic ofd, output logic oerr);
    @(posedge clk); #1 ptr_req = 1'b1;
    @(posedge clk); #1 ptr_req = 1'b0;
    if (frz_rd > 0) begin
      en = 1'b0;
      for (int i = 0; i < frz_rd; i++) begin
        @(posedge clk); #1;
        if (req_in_frz && i == 1) ptr_req = 1'b1;
        if (i == 2) ptr_req = 1'b0;
      end
      en = 1'b1;
    end
    @(posedge clk); #1 model_issue();
    opc = pc; ow = instr_word; ofd = frame_done; oerr = seq_err;
    $display("req: pc=%0d word=%06h frame_done=%0b seq_err=%0b", pc, instr_word, frame_done, seq_err);
    if (frz_is > 0) begin
      en = 1'b0;
      repeat (frz_is) begin @(posedge clk); #1; end
      en = 1'b1;
    end
    @(posedge clk); #1 exp_valid = 1'b0; exp_fd = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [PC_W-1:0] r_pc;
  logic [IW-1:0]   r_w;
  logic            r_fd, r_err;
  logic [IW-1:0]   w3 [3];
  int              pcs3 [4];
  int              fds3 [4];

  initial begin
    pcs3 = '{0, 1, 2, 0};
    fds3 = '{0, 0, 1, 0};
    w3[0] = mk(1'b0, 1'b1, 2'd1, 2'd2, 4'h3, 4'h5, 4'h1);
    w3[1] = mk(1'b0, 1'b0, 2'd3, 2'd0, 4'hA, 4'h6, 4'h7);
    w3[2] = mk(1'b1, 1'b0, 2'd2, 2'd1, 4'hC, 4'h9, 4'hE);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_iw_valid", 32'(iw_valid), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_instr", 32'(instr_word), 32'd0);
    chk("reset_seq_err", 32'(seq_err), 32'd0);

    // Three-stage program, last stage flagged.
    enter_prog();
    for (int i = 0; i < 3; i++) wr(i, w3[i]);
    exit_prog();

    for (int i = 0; i < 4; i++) begin
      do_req(0, 0, 1'b0, r_pc, r_w, r_fd, r_err);
      chk("seq_pc", 32'(r_pc), 32'(pcs3[i]));
      chk("seq_fd", 32'(r_fd), 32'(fds3[i]));
      chk("seq_word", 32'(r_w), 32'(w3[i % 3]));
      chk("seq_hptr", 32'(r_w[7:4]), 32'h8);
    end

    // No last-stage flag anywhere: wrap with error.
    enter_prog();
    for (int i = 0; i < PS; i++)
      wr(i, mk(1'b0, 1'(i), 2'(i), 2'(i >> 2), 4'(i >> 1), 4'(~i), 4'(i)));
    exit_prog();
    for (int i = 0; i < PS + 1; i++) begin
      do_req(0, 0, 1'b0, r_pc, r_w, r_fd, r_err);
      chk("wrap_pc", 32'(r_pc), 32'(i % PS));
      chk("wrap_seq_err", 32'(r_err), (i >= PS - 1) ? 32'd1 : 32'd0);
      chk("wrap_fd", 32'(r_fd), 32'd0);
    end
    enter_prog();
    chk("prog_clears_seq_err", 32'(seq_err), 32'd0);
    exit_prog();

    // Freeze in READ for 5 cycles (with an ignored request), then 2 in ISSUE.
    do_req(5, 2, 1'b1, r_pc, r_w, r_fd, r_err);
    chk("freeze_pc", 32'(r_pc), 32'd0);
    chk("freeze_word", 32'(r_w), 32'(mk(1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 4'hF, 4'h0)));
    do_req(0, 0, 1'b0, r_pc, r_w, r_fd, r_err);
    chk("after_freeze_pc", 32'(r_pc), 32'd1);

    // Abort in READ; then a write strobe without prog must be ignored.
    @(posedge clk); #1 ptr_req = 1'b1;
    @(posedge clk); #1 ptr_req = 1'b0; prog = 1'b1;
    @(posedge clk); #1 model_prog_clear();
    chk("abort_iw_valid", 32'(iw_valid), 32'd0);
    @(posedge clk); #1 chk("abort_iw_valid2", 32'(iw_valid), 32'd0);
    exit_prog();
    prog_we = 1'b1; prog_addr = '0; prog_wdata = 22'h3FFFFF;
    @(posedge clk); #1 prog_we = 1'b0;
    do_req(0, 0, 1'b0, r_pc, r_w, r_fd, r_err);
    chk("abort_restart_pc", 32'(r_pc), 32'd0);
    chk("abort_restart_word", 32'(r_w), 32'(mk(1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 4'hF, 4'h0)));

    // Async reset in the ISSUE cycle of the word at pc 1.
    @(posedge clk); #1 ptr_req = 1'b1;
    @(posedge clk); #1 ptr_req = 1'b0;
    @(posedge clk); #1 model_issue();
    chk("pre_reset_iw_valid", 32'(iw_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_iw_valid", 32'(iw_valid), 32'd0);
    chk("async_pc", 32'(pc), 32'd0);
    chk("async_fd", 32'(frame_done), 32'd0);
    exp_valid = 1'b0; exp_fd = 1'b0; exp_err = 1'b0; exp_pc = '0; exp_word = '0; mdl_npc = 0;
    @(posedge clk); #1 rst = 1'b0;
    do_req(0, 0, 1'b0, r_pc, r_w, r_fd, r_err);
    chk("post_reset_pc", 32'(r_pc), 32'd0);

    // Single-instruction program.
    enter_prog();
    wr(0, w3[2]);
    exit_prog();
    for (int i = 0; i < 2; i++) begin
      do_req(0, 0, 1'b0, r_pc, r_w, r_fd, r_err);
      chk("single_pc", 32'(r_pc), 32'd0);
      chk("single_fd", 32'(r_fd), 32'd1);
      chk("single_word", 32'(r_w), 32'(w3[2]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
